calc_op_sequencer: RTL and testbench



---
 rtl/calc_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
//   Program sequencer for the calculator datapath. A small program of
//   (opcode, operand) slots is loaded while idle; on start every slot is
//   issued to the core with the 3-cycle enter protocol (SETUP -> STROBE ->
//   SETTLE), and the core's result/flags are captured at the end of each
//   SETTLE. done pulses once when the run completes.
//
//   Optional feature (macro CALC_SEQ_REPEAT_EN): adds rep_count; the program
//   runs rep_count+1 times back-to-back with a single done pulse at the end.
//
// Ports
//   clk, rst                     clock (rising), async active-high reset
//   prog_we/addr/op/data         program slot write (honoured only in IDLE)
//   len                          slots to run, clamped to DEPTH, sampled at start
//   start, abort                 run control (abort wins over everything)
//   rep_count                    extra passes (CALC_SEQ_REPEAT_EN only)
//   busy, done                   run in progress / one-cycle completion pulse
//   result, flags                last captured datapath result and flags
//   calc_op/data/strobe          drive to the calculator core
//   calc_result/flags            from the calculator core
module calc_op_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8,
    parameter int OPW   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prog_we,
    input  logic [AW-1:0]  prog_addr,
    input  logic [OPW-1:0] prog_op,
    input  logic [DW-1:0]  prog_data,
    input  logic [AW:0]    len,
    input  logic           start,
    input  logic           abort,
`ifdef CALC_SEQ_REPEAT_EN
    input  logic [3:0]     rep_count,
`endif
    output logic           busy,
    output logic           done,
    output logic [DW-1:0]  result,
    output logic [2:0]     flags,
    output logic [OPW-1:0] calc_op,
    output logic [DW-1:0]  calc_data,
    output logic           calc_strobe,
    input  logic [DW-1:0]  calc_result,
    input  logic [2:0]     calc_flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_SETTLE,
        S_FIN
    } state_t;

    state_t state, state_n;

    logic [OPW+DW-1:0] mem [DEPTH];

    logic [AW-1:0] pc, pc_n;
    logic [AW-1:0] last, last_n;       // index of the final slot of a pass
    logic [3:0]    rep_left, rep_n;    // passes still to run after this one
    logic [3:0]    rep_load;
    logic [AW:0]   len_c;
    logic          capture;
    logic [OPW+DW-1:0] slot_n;

`ifdef CALC_SEQ_REPEAT_EN
    assign rep_load = rep_count;
`else
    assign rep_load = 4'd0;
`endif

    assign len_c  = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign slot_n = mem[pc_n];

    // Program memory has no reset; writes are locked out for the whole run.
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE)
            mem[prog_addr] <= {prog_op, prog_data};
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        last_n  = last;
        rep_n   = rep_left;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    pc_n  = '0;
                    rep_n = rep_load;
                    if (len_c == '0) begin
                        state_n = S_FIN;
                    end else begin
                        state_n = S_SETUP;
                        last_n  = AW'(len_c - 1'b1);
                    end
                end
            end
            S_SETUP:  state_n = S_STROBE;
            S_STROBE: state_n = S_SETTLE;
            S_SETTLE: begin
                // Core result is stable during SETTLE (it updated on the
                // strobe edge), so it is sampled as SETTLE closes.
                capture = 1'b1;
                if (pc == last) begin
                    if (rep_left != 4'd0) begin
                        rep_n   = rep_left - 4'd1;
                        pc_n    = '0;
                        state_n = S_SETUP;
                    end else begin
                        state_n = S_FIN;
                    end
                end else begin
                    pc_n    = pc + 1'b1;
                    state_n = S_SETUP;
                end
            end
            S_FIN:    state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        // Abort overrides every transition, including the SETTLE capture.
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            capture = 1'b0;
        end
    end

    // Outputs are registered from the next state so each one is valid
    // during the cycle the FSM spends in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            last        <= '0;
            rep_left    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            flags       <= '0;
            calc_op     <= '0;
            calc_data   <= '0;
            calc_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            last        <= last_n;
            rep_left    <= rep_n;
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_FIN);
            calc_strobe <= (state_n == S_STROBE);
            if (state_n == S_SETUP) begin
                calc_op   <= slot_n[OPW+DW-1:DW];
                calc_data <= slot_n[DW-1:0];
            end
            if (capture) begin
                result <= calc_result;
                flags  <= calc_flags;
            end
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [2:0] prog_addr = '0;
    logic [3:0] prog_op = '0;
    logic [7:0] prog_data = '0;
    logic [3:0] len = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
`ifdef CALC_SEQ_REPEAT_EN
    logic [3:0] rep_count = '0;
`endif
    logic       busy, done, calc_strobe;
    logic [7:0] result, calc_data, calc_result;
    logic [2:0] flags, calc_flags;
    logic [3:0] calc_op;

    calc_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op), .prog_data(prog_data),
        .len(len), .start(start), .abort(abort),
`ifdef CALC_SEQ_REPEAT_EN
        .rep_count(rep_count),
`endif
        .busy(busy), .done(done), .result(result), .flags(flags),
        .calc_op(calc_op), .calc_data(calc_data), .calc_strobe(calc_strobe),
        .calc_result(calc_result), .calc_flags(calc_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Calculator core stand-in: accumulator updated on each enter strobe.
    function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d);
        case (op)
            4'h0:    alu = {1'b0, a} + {1'b0, d};
            4'h1:    alu = {1'b0, a} - {1'b0, d};
            4'h2:    alu = {1'b0, a & d};
            4'h3:    alu = {1'b0, a | d};
            4'h4:    alu = {1'b0, a ^ d};
            4'h5:    alu = {a, 1'b0};
            default: alu = {1'b0, d};
        endcase
    endfunction

    logic [7:0] dp_acc;
    logic       dp_c;
    always @(posedge clk or posedge rst) begin
        if (rst) {dp_c, dp_acc} <= '0;
        else if (calc_strobe) {dp_c, dp_acc} <= alu(calc_op, dp_acc, calc_data);
    end
    assign calc_result = dp_acc;
    assign calc_flags  = {dp_acc == 8'h00, dp_acc[7], dp_c};

    // Bus monitor (negedge): strobe log, op/data setup stability, done log.
    logic [11:0] sq[$];
    int          sc[$];
    int          done_cnt = 0, done_cyc = 0, stab_err = 0;
    logic [11:0] prev_od = '0;
    bit          mon_en = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (calc_strobe) begin
                sq.push_back({calc_op, calc_data});
                sc.push_back(cyc);
                if ({calc_op, calc_data} !== prev_od) stab_err++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_od = {calc_op, calc_data};
    end

    // Reference model state
    logic [11:0] mem_m [DEPTH];
    logic [7:0]  acc_m = '0, res_m = '0;
    logic        cy_m = 1'b0;
    logic [2:0]  flg_m = '0;

    int passed = 0, failed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [3:0] op, input logic [7:0] d);
        @(posedge clk); #3;
        prog_we = 1'b1; prog_addr = 3'(a); prog_op = op; prog_data = d;
        mem_m[a] = {op, d};
        @(posedge clk); #3;
        prog_we = 1'b0;
    endtask

    // Runs one program. abort_r / poke_r are cycle offsets from the start
    // cycle (-1 = none); poke drives start and a slot-0 write while busy.
    task automatic run(input int ln, input int rep, input int abort_r, input int poke_r);
        int n, t, st_e, cp_e, c, serr, ncyc;
        logic [11:0] flat[$];
        logic [10:0] hist[$];
        n = (ln > DEPTH) ? DEPTH : ln;
        for (int p = 0; p <= rep; p++)
            for (int k = 0; k < n; k++) flat.push_back(mem_m[k]);
        t = flat.size();
        st_e = 0; cp_e = 0;
        for (int k = 0; k < t; k++) begin
            if (abort_r < 0 || 3*k + 2 <= abort_r) st_e++;
            if (abort_r < 0 || 3*k + 3 <  abort_r) cp_e++;
        end
        for (int k = 0; k < st_e; k++) begin
            {cy_m, acc_m} = alu(flat[k][11:8], acc_m, flat[k][7:0]);
            hist.push_back({acc_m == 8'h00, acc_m[7], cy_m, acc_m});
        end
        if (cp_e > 0) {flg_m, res_m} = hist[cp_e-1];

        sq.delete(); sc.delete();
        done_cnt = 0; stab_err = 0; mon_en = 1;
        @(posedge clk); #3;
        c = cyc; len = 4'(ln); start = 1'b1;
`ifdef CALC_SEQ_REPEAT_EN
        rep_count = 4'(rep);
`endif
        ncyc = (abort_r < 0) ? 3*t + 6 : abort_r + 12;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk); #3;
            start = 1'b0; prog_we = 1'b0; abort = 1'b0;
            if (i == 1 && t > 0) chk("busy_run", busy, 1);
            if (i == poke_r) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = '0;
                prog_op = 4'($urandom); prog_data = 8'($urandom);
            end
            if (i == abort_r) abort = 1'b1;
            if (abort_r >= 0 && i == abort_r + 1) begin
                chk("busy_abort", busy, 0);
                chk("strobe_abort", calc_strobe, 0);
            end
        end
        mon_en = 0;
        serr = 0;
        for (int k = 0; k < sq.size() && k < t; k++)
            if (sq[k] !== flat[k] || sc[k] - c != 3*k + 2) serr++;
        chk("strobes", sq.size(), st_e);
        chk("seq", serr, 0);
        chk("setup_stable", stab_err, 0);
        chk("done_cnt", done_cnt, (abort_r < 0) ? 1 : 0);
        if (abort_r < 0) chk("done_lat", done_cyc - c, 3*t + 1);
        chk("result", result, res_m);
        chk("flags", flags, flg_m);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_op", calc_op, 0);
        chk("rst_data", calc_data, 0);
        chk("rst_strobe", calc_strobe, 0);
        rst = 1'b0;

        // two ADDs
        load(0, 4'h0, 8'h05);
        load(1, 4'h0, 8'h03);
        run(2, 0, -1, -1);
        chk("add_result", result, 8'h08);

        // ADD, SUB, XOR, LSHIFT
        load(0, 4'h0, 8'h0F);
        load(1, 4'h1, 8'h05);
        load(2, 4'h4, 8'hFF);
        load(3, 4'h5, 8'h00);
        run(4, 0, -1, -1);

        // empty program
        run(0, 0, -1, -1);

        // abort in second slot's SETUP, with a write and start mid-run
        for (int k = 0; k < 3; k++) load(k, 4'($urandom_range(0, 7)), 8'($urandom));
        run(3, 0, 4, 2);
        run(3, 0, -1, -1);

        // random programs and lengths
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < DEPTH; k++) load(k, 4'($urandom_range(0, 7)), 8'($urandom));
            run(int'($urandom_range(0, 15)), 0, -1, -1);
        end

        // len above DEPTH clamps, start/write while busy ignored
        run(12, 0, -1, 5);
        run(8, 0, -1, -1);

        // asynchronous reset during a strobe
        @(posedge clk); #3;
        len = 4'd4; start = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
        for (int i = 0; i < 10 && !calc_strobe; i++) begin
            @(posedge clk); #3;
        end
        chk("strobe_pre_rst", calc_strobe, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_strobe", calc_strobe, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_result", result, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        acc_m = '0; cy_m = 1'b0; res_m = '0; flg_m = '0;
        run(DEPTH, 0, -1, -1);

`ifdef CALC_SEQ_REPEAT_EN
        rst = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
        acc_m = '0; cy_m = 1'b0; res_m = '0; flg_m = '0;
        load(0, 4'h0, 8'h01);
        run(1, 2, -1, -1);
        chk("rep_result", result, 8'h03);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
